// File: rtl/wb_intgen_pkg.sv
// wb_intgen_pkg: register map, mode encoding and bus states for wb_intgen_mc
package wb_intgen_pkg;
  localparam logic [31:0] REG_PEND = 32'd0;
  localparam logic [31:0] REG_MASK = 32'd1;
  localparam logic [31:0] REG_MODE = 32'd2;
  localparam logic [31:0] REG_INFO = 32'd3;
  localparam logic [31:0] REG_COUNT0 = 32'd4;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_ERR} bus_state_e;
endpackage

// File: rtl/intgen_chan.sv
// intgen_chan: one down-counter channel with one-shot or periodic reload
module intgen_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             periodic,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  logic [CNT_W-1:0] reload;
  assign expire = count == CNT_W'(1);
  // a load overrides the decrement/reload; periodic channels refill on the 1->0 edge
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      reload <= '0;
    end else if (load) begin
      count <= load_val;
      reload <= load_val;
    end else if (count != '0)
      count <= (expire && periodic && reload != '0) ? reload : count - CNT_W'(1);
endmodule

// File: rtl/wb_intgen_mc.sv
// wb_intgen_mc: multi-channel Wishbone interrupt generator with per-channel down-counters
module wb_intgen_mc
  import wb_intgen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int AW = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [NUM_CH-1:0] irq_vec_o,
  output logic              irq_o
);
  bus_state_e state, state_nxt;
  logic [31:0] adr, rdata;
  logic req, mapped, wr, unused;
  logic [NUM_CH-1:0] pending, mask, mode, expire, clr;
  logic [CNT_W-1:0] count [NUM_CH];
  assign adr = 32'(wb_adr_i);
  assign req = wb_cyc_i & wb_stb_i & (state == BUS_IDLE);
  assign mapped = adr < REG_COUNT0 + 32'(NUM_CH);
  assign wr = req & wb_we_i & mapped;
  assign clr = (wr && adr == REG_PEND) ? wb_dat_i[NUM_CH-1:0] : '0;
  assign wb_ack_o = state == BUS_ACK;
  assign wb_err_o = state == BUS_ERR;
  assign irq_o = |irq_vec_o;
  assign unused = ^wb_dat_i;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    intgen_chan #(.CNT_W(CNT_W)) u_chan (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .load(wr && adr == REG_COUNT0 + 32'(c)),
      .load_val(wb_dat_i[CNT_W-1:0]),
      .periodic(mode[c] == MODE_PERIODIC),
      .count(count[c]),
      .expire(expire[c])
    );
  end
  // every request gets a single-cycle ack or err; a held strobe re-requests after it
  always_comb state_nxt = req ? (mapped ? BUS_ACK : BUS_ERR) : BUS_IDLE;
  // read data mux over the control registers and channel counts
  always_comb begin
    rdata = adr == REG_PEND ? 32'(pending) :
            adr == REG_MASK ? 32'(mask) :
            adr == REG_MODE ? 32'(mode) :
            adr == REG_INFO ? {8'd0, 8'(CNT_W), 8'd0, 8'(NUM_CH)} : '0;
    for (int i = 0; i < NUM_CH; i++)
      if (adr == REG_COUNT0 + 32'(i)) rdata = 32'(count[i]);
  end
  // bus state and registered read data, zero outside a read response
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= BUS_IDLE;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      wb_dat_o <= (req && !wb_we_i && mapped) ? rdata : '0;
    end
  // pending is sticky with hardware set winning over W1C; irq vector lags pending by one cycle
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      pending <= '0;
      mask <= '0;
      mode <= {NUM_CH{MODE_ONESHOT}};
      irq_vec_o <= '0;
    end else begin
      pending <= (pending & ~clr) | expire;
      irq_vec_o <= pending & mask;
      if (wr && adr == REG_MASK) mask <= wb_dat_i[NUM_CH-1:0];
      if (wr && adr == REG_MODE) mode <= wb_dat_i[NUM_CH-1:0];
    end
endmodule

// File: tb/tb_wb_intgen_mc.sv
// tb_wb_intgen_mc: scoreboard bench for wb_intgen_mc with directed vectors
module tb_wb_intgen_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 16;
  localparam int AW = 5;
  localparam logic [31:0] INFO = 32'h0010_0004;
  logic clk = 0;
  logic rst = 1;
  logic [AW-1:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic we = 0;
  logic cyc = 0;
  logic stb = 0;
  logic [31:0] dat_o;
  logic ack, err;
  logic [NUM_CH-1:0] irq_vec;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  wb_intgen_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .AW(AW)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_i),
    .wb_we_i(we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .irq_vec_o(irq_vec),
    .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // monitor: every ack/err response is matched against the oldest expected entry
  always @(negedge clk)
    if (ack || err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp got ack=%0b err=%0b want none", ack, err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, ack, err}, e[32] ? 32'd1 : 32'd2);
        check("resp_data", dat_o, e[31:0]);
      end
    end else
      check("idle_dat", dat_o, 32'd0);
  task automatic bus(input logic w, input int a, input logic [31:0] d, input logic [32:0] e);
    @(posedge clk);
    #1;
    we = w;
    adr = AW'(a);
    dat_i = d;
    cyc = 1;
    stb = 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc = 0;
    stb = 0;
    we = 0;
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    bus(1'b1, a, d, {1'b0, 32'd0});
  endtask
  task automatic rd(input int a, input logic [31:0] d);
    bus(1'b0, a, 32'd0, {1'b0, d});
  endtask
  task automatic irq_next(input string name, input logic v);
    @(posedge clk);
    #1;
    check(name, 32'(irq), 32'(v));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_irq_vec", 32'(irq_vec), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 0;
    rd(3, INFO);
    rd(0, 0);
    rd(1, 0);
    rd(2, 0);
    // one-shot: pending at write edge +5, irq one cycle later
    wr(1, 32'h1);
    wr(4, 5);
    repeat (5) @(posedge clk);
    #1;
    check("oneshot_irq_early", 32'(irq), 0);
    irq_next("oneshot_irq", 1);
    rd(4, 0);
    rd(0, 32'h1);
    wr(0, 32'h1);
    check("w1c_irq_hold", 32'(irq), 1);
    irq_next("w1c_irq_drop", 0);
    // periodic: expiries at write edge +3, +6, +9
    wr(2, 32'h2);
    wr(1, 32'h2);
    wr(5, 3);
    repeat (3) @(posedge clk);
    #1;
    check("per_irq_early", 32'(irq), 0);
    irq_next("per_irq1", 1);
    @(posedge clk);
    wr(0, 32'h2);
    check("per_irq_before_clr", 32'(irq), 1);
    irq_next("per_irq_clr", 0);
    irq_next("per_irq_gap", 0);
    irq_next("per_irq_reset", 1);
    wr(5, 0);
    wr(0, 32'h2);
    repeat (8) @(posedge clk);
    rd(5, 0);
    rd(0, 0);
    // W1C on the expiry edge: set wins
    wr(6, 3);
    @(posedge clk);
    wr(0, 32'h4);
    rd(0, 32'h4);
    wr(0, 32'h4);
    rd(0, 0);
    // channels 0 and 3 expire on the same edge
    wr(7, 4);
    wr(4, 2);
    repeat (3) @(posedge clk);
    rd(0, 32'h9);
    wr(0, 32'h9);
    // masked channel still pends; unmask raises irq next cycle
    wr(2, 0);
    wr(1, 0);
    wr(5, 2);
    repeat (4) @(posedge clk);
    rd(0, 32'h2);
    check("masked_irq", 32'(irq), 0);
    wr(1, 32'h2);
    check("unmask_irq_early", 32'(irq), 0);
    irq_next("unmask_irq", 1);
    // unmapped offset and read-only INFO
    bus(1'b0, 8, 32'd0, {1'b1, 32'd0});
    bus(1'b1, 8, 32'hF, {1'b1, 32'd0});
    rd(1, 32'h2);
    wr(3, 32'hFFFF_FFFF);
    rd(3, INFO);
    // held strobe: ack alternates
    @(posedge clk);
    #1;
    adr = AW'(3);
    cyc = 1;
    stb = 1;
    exp_q.push_back({1'b0, INFO});
    exp_q.push_back({1'b0, INFO});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("held_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 0;
    stb = 0;
    // reset mid-countdown with a write in flight
    wr(1, 32'h1);
    wr(6, 100);
    wr(4, 1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_irq", 32'(irq), 1);
    rst = 1;
    adr = AW'(1);
    dat_i = 32'hF;
    we = 1;
    cyc = 1;
    stb = 1;
    @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(ack), 0);
    check("rst_mid_err", 32'(err), 0);
    check("rst_mid_irq", 32'(irq), 0);
    rst = 0;
    cyc = 0;
    stb = 0;
    we = 0;
    rd(6, 0);
    rd(0, 0);
    rd(1, 0);
    check("post_rst_irq", 32'(irq), 0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
